// File: rtl/run_ctrl.sv
// Pipeline execution controller: halt / free-run / single-step / N-step burst
// with PC breakpoints, producing a one-cycle pipe_en advance strobe.
module run_ctrl #(
  parameter int PC_W   = 16,
  parameter int CNT_W  = 16,
  parameter int DIV_W  = 26,
  parameter int NUM_BP = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   step_btn,
  input  logic                   resume,
  input  logic [DIV_W-1:0]       rate_div,
  input  logic [CNT_W-1:0]       burst_len,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [PC_W-1:0]        pc,
  output logic                   pipe_en,
  output logic                   running,
  output logic                   in_break,
  output logic [2:0]             bp_idx,
  output logic [CNT_W-1:0]       adv_count,
  output logic [CNT_W-1:0]       burst_left
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_FREE  = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  state_t             state_r, state_next_s;
  state_t             ret_r, ret_next_s;
  logic               step_q_r, res_q_r;
  logic               step_rise_r, res_rise_r;
  logic [DIV_W-1:0]   div_r;
  logic               tick_s;
  logic               bp_hit_s;
  logic [2:0]         hit_idx_s;
  logic               skip_r, skip_next_s;
  logic               pipe_en_r, pipe_next_s;
  logic               running_r, in_break_r;
  logic [2:0]         bp_idx_r, bp_idx_next_s;
  logic [CNT_W-1:0]   adv_count_r;
  logic [CNT_W-1:0]   burst_left_r, burst_next_s;

  assign tick_s = (div_r == rate_div);

  // Button/resume edge detection; reset preloads the history so a held level is not an edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      step_q_r    <= step_btn;
      res_q_r     <= resume;
      step_rise_r <= 1'b0;
      res_rise_r  <= 1'b0;
    end else begin
      step_q_r    <= step_btn;
      res_q_r     <= resume;
      step_rise_r <= step_btn & ~step_q_r;
      res_rise_r  <= resume & ~res_q_r;
    end
  end

  // Rate divider: counts only while advancing, so entering RUN/BURST always starts from 0.
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_r <= {DIV_W{1'b0}};
    end else if ((state_r == ST_RUN) || (state_r == ST_BURST)) begin
      div_r <= tick_s ? {DIV_W{1'b0}} : (div_r + DIV_W'(1));
    end else begin
      div_r <= {DIV_W{1'b0}};
    end
  end

  // Breakpoint comparators; scanning high-to-low lets the lowest matching index win.
  always_comb begin
    bp_hit_s  = 1'b0;
    hit_idx_s = 3'd0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (pc == bp_addr[i*PC_W +: PC_W])) begin
        bp_hit_s  = 1'b1;
        hit_idx_s = 3'(i);
      end else begin
        bp_hit_s  = bp_hit_s;
      end
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_next_s  = state_r;
    ret_next_s    = ret_r;
    pipe_next_s   = 1'b0;
    burst_next_s  = burst_left_r;
    skip_next_s   = skip_r;
    bp_idx_next_s = bp_idx_r;
    case (state_r)
      ST_IDLE: begin
        skip_next_s = 1'b0;
        case (mode)
          MODE_FREE: begin
            state_next_s = ST_RUN;
          end
          MODE_STEP: begin
            pipe_next_s = step_rise_r;
          end
          MODE_BURST: begin
            if (step_rise_r) begin
              state_next_s = ST_BURST;
              burst_next_s = (burst_len == {CNT_W{1'b0}}) ? CNT_W'(1) : burst_len;
            end else begin
              state_next_s = ST_IDLE;
            end
          end
          default: begin
            state_next_s = ST_IDLE;
          end
        endcase
      end
      ST_RUN: begin
        // Mode is checked before the tick so no strobe accompanies the exit.
        if (mode != MODE_FREE) begin
          state_next_s = ST_IDLE;
        end else if (tick_s) begin
          if (bp_hit_s && !skip_r) begin
            state_next_s  = ST_BREAK;
            ret_next_s    = ST_RUN;
            bp_idx_next_s = hit_idx_s;
          end else begin
            pipe_next_s = 1'b1;
            skip_next_s = 1'b0;
          end
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_BURST: begin
        if (mode == MODE_HALT) begin
          state_next_s = ST_IDLE;
          burst_next_s = {CNT_W{1'b0}};
        end else if (tick_s) begin
          if (bp_hit_s && !skip_r) begin
            state_next_s  = ST_BREAK;
            ret_next_s    = ST_BURST;
            bp_idx_next_s = hit_idx_s;
          end else begin
            pipe_next_s  = 1'b1;
            skip_next_s  = 1'b0;
            if (burst_left_r <= CNT_W'(1)) begin
              burst_next_s = {CNT_W{1'b0}};
              state_next_s = ST_IDLE;
            end else begin
              burst_next_s = burst_left_r - CNT_W'(1);
            end
          end
        end else begin
          state_next_s = ST_BURST;
        end
      end
      ST_BREAK: begin
        if (mode == MODE_HALT) begin
          state_next_s = ST_IDLE;
          skip_next_s  = 1'b0;
          burst_next_s = {CNT_W{1'b0}};
        end else if (res_rise_r) begin
          // skip lets the breakpoint instruction execute once after resume.
          skip_next_s  = 1'b1;
          state_next_s = ret_r;
        end else begin
          state_next_s = ST_BREAK;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, strobe, counters and status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      ret_r        <= ST_RUN;
      pipe_en_r    <= 1'b0;
      burst_left_r <= {CNT_W{1'b0}};
      skip_r       <= 1'b0;
      bp_idx_r     <= 3'd0;
      adv_count_r  <= {CNT_W{1'b0}};
      running_r    <= 1'b0;
      in_break_r   <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      ret_r        <= ret_next_s;
      pipe_en_r    <= pipe_next_s;
      burst_left_r <= burst_next_s;
      skip_r       <= skip_next_s;
      bp_idx_r     <= bp_idx_next_s;
      adv_count_r  <= pipe_next_s ? (adv_count_r + CNT_W'(1)) : adv_count_r;
      running_r    <= (state_next_s == ST_RUN) || (state_next_s == ST_BURST);
      in_break_r   <= (state_next_s == ST_BREAK);
    end
  end

  assign pipe_en    = pipe_en_r;
  assign running    = running_r;
  assign in_break   = in_break_r;
  assign bp_idx     = bp_idx_r;
  assign adv_count  = adv_count_r;
  assign burst_left = burst_left_r;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed self-checking bench for run_ctrl; the bench models the pipeline PC
// by incrementing pc on each pipe_en strobe.
module tb_run_ctrl;

  logic        clock;
  logic        reset;
  logic [1:0]  mode;
  logic        step_btn;
  logic        resume;
  logic [25:0] rate_div;
  logic [15:0] burst_len;
  logic [31:0] bp_addr;
  logic [1:0]  bp_en;
  logic [15:0] pc;
  logic        pipe_en;
  logic        running;
  logic        in_break;
  logic [2:0]  bp_idx;
  logic [15:0] adv_count;
  logic [15:0] burst_left;

  int checks;
  int errors;
  logic [15:0] strobe_pc;

  run_ctrl #(.PC_W(16), .CNT_W(16), .DIV_W(26), .NUM_BP(2)) dut (
    .clock(clock), .reset(reset), .mode(mode), .step_btn(step_btn),
    .resume(resume), .rate_div(rate_div), .burst_len(burst_len),
    .bp_addr(bp_addr), .bp_en(bp_en), .pc(pc), .pipe_en(pipe_en),
    .running(running), .in_break(in_break), .bp_idx(bp_idx),
    .adv_count(adv_count), .burst_left(burst_left)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock; sample 1 time unit after the edge and advance the modelled PC.
  task automatic tick_clk();
    @(posedge clock);
    #1;
    if (pipe_en) begin
      strobe_pc = pc;
      pc = pc + 16'd1;
    end
  endtask

  task automatic test_reset();
    int pulses;
    reset = 1'b0; step_btn = 1'b1; resume = 1'b1; mode = 2'b10;
    rate_div = 26'd0; burst_len = 16'd0; bp_addr = 32'd0; bp_en = 2'b00; pc = 16'd0;
    repeat (3) tick_clk();
    checks++; if (pipe_en !== 1'b0) begin errors++; $display("FAIL reset_pipe_en: got %0b want 0", pipe_en); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b want 0", running); end
    checks++; if (in_break !== 1'b0) begin errors++; $display("FAIL reset_in_break: got %0b want 0", in_break); end
    checks++; if (bp_idx !== 3'd0) begin errors++; $display("FAIL reset_bp_idx: got %0d want 0", bp_idx); end
    checks++; if (burst_left !== 16'd0) begin errors++; $display("FAIL reset_burst_left: got %0d want 0", burst_left); end
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick_clk();
      if (pipe_en) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL held_step_after_reset: got %0d strobes want 0", pulses); end
    checks++; if (adv_count !== 16'd0) begin errors++; $display("FAIL reset_adv_count: got %0d want 0", adv_count); end
    step_btn = 1'b0; resume = 1'b0; mode = 2'b00;
    repeat (2) tick_clk();
  endtask

  task automatic test_free_run();
    int pulses;
    int last_k;
    bit gap_bad;
    rate_div = 26'd3; bp_en = 2'b00; mode = 2'b01;
    tick_clk();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL free_running: got %0b want 1", running); end
    pulses = 0; last_k = -1; gap_bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick_clk();
      if (pipe_en) begin
        pulses++;
        if (last_k >= 0 && (k - last_k) != 4) gap_bad = 1'b1;
        last_k = k;
      end
    end
    checks++; if (pulses !== 10) begin errors++; $display("FAIL free_pulses: got %0d want 10", pulses); end
    checks++; if (gap_bad !== 1'b0) begin errors++; $display("FAIL free_period: got irregular spacing want 4"); end
    checks++; if (adv_count !== 16'd10) begin errors++; $display("FAIL free_adv_count: got %0d want 10", adv_count); end
    mode = 2'b00;
    tick_clk();
    checks++; if (pipe_en !== 1'b0) begin errors++; $display("FAIL free_exit_strobe: got %0b want 0", pipe_en); end
    tick_clk();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL free_exit_running: got %0b want 0", running); end
  endtask

  task automatic test_step();
    int pulses;
    int first_k;
    bit prev;
    bit consec;
    mode = 2'b10; rate_div = 26'd7;
    pulses = 0; first_k = -1; prev = 1'b0; consec = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 10; k++) begin
        step_btn = (k < 5);
        tick_clk();
        if (pipe_en) begin
          pulses++;
          if (prev) consec = 1'b1;
          if (p == 0 && first_k < 0) first_k = k;
        end
        prev = pipe_en;
      end
    end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL step_pulses: got %0d want 3", pulses); end
    checks++; if (consec !== 1'b0) begin errors++; $display("FAIL step_width: got multi-cycle strobe want single"); end
    checks++; if (first_k !== 1) begin errors++; $display("FAIL step_latency: got cycle %0d want 1", first_k); end
    checks++; if (adv_count !== 16'd13) begin errors++; $display("FAIL step_adv_count: got %0d want 13", adv_count); end
  endtask

  task automatic test_burst();
    logic [11:0] pv;
    logic [15:0] bl1, bl6;
    logic        run1, run11;
    int pulses;
    mode = 2'b11; burst_len = 16'd5; rate_div = 26'd0; step_btn = 1'b0;
    tick_clk();
    step_btn = 1'b1;
    pv = 12'd0; bl1 = 16'hffff; bl6 = 16'hffff; run1 = 1'b0; run11 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick_clk();
      pv[k] = pipe_en;
      if (k == 1) begin bl1 = burst_left; run1 = running; end
      if (k == 6) bl6 = burst_left;
      if (k == 11) run11 = running;
      if (k == 2) step_btn = 1'b0;
      if (k == 3) step_btn = 1'b1;
    end
    checks++; if (pv !== 12'h07C) begin errors++; $display("FAIL burst_pattern: got %03h want 07c", pv); end
    checks++; if (bl1 !== 16'd5) begin errors++; $display("FAIL burst_left_start: got %0d want 5", bl1); end
    checks++; if (bl6 !== 16'd0) begin errors++; $display("FAIL burst_left_end: got %0d want 0", bl6); end
    checks++; if (run1 !== 1'b1) begin errors++; $display("FAIL burst_running: got %0b want 1", run1); end
    checks++; if (run11 !== 1'b0) begin errors++; $display("FAIL burst_idle_after: got %0b want 0", run11); end
    checks++; if (adv_count !== 16'd18) begin errors++; $display("FAIL burst_adv_count: got %0d want 18", adv_count); end
    burst_len = 16'd0; step_btn = 1'b0;
    repeat (2) tick_clk();
    step_btn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick_clk();
      if (pipe_en) pulses++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL burst_len_zero: got %0d strobes want 1", pulses); end
    checks++; if (adv_count !== 16'd19) begin errors++; $display("FAIL burst0_adv_count: got %0d want 19", adv_count); end
    step_btn = 1'b0; mode = 2'b00;
    repeat (2) tick_clk();
  endtask

  task automatic test_breakpoint();
    int pulses;
    bit seen;
    logic [15:0] first_pc;
    pc = 16'h000C; bp_addr = {16'h0010, 16'h0010}; bp_en = 2'b11;
    rate_div = 26'd0; resume = 1'b0; mode = 2'b01;
    pulses = 0; seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      tick_clk();
      if (pipe_en) pulses++;
      if (in_break) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL bp_timeout: got no break want in_break within 30 cycles"); end
    checks++; if (pulses !== 4) begin errors++; $display("FAIL bp_pulses_before: got %0d want 4", pulses); end
    checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL bp_pc: got %04h want 0010", pc); end
    checks++; if (bp_idx !== 3'd0) begin errors++; $display("FAIL bp_idx_lowest: got %0d want 0", bp_idx); end
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick_clk();
      if (pipe_en) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL bp_hold: got %0d strobes want 0", pulses); end
    checks++; if (in_break !== 1'b1) begin errors++; $display("FAIL bp_hold_state: got %0b want 1", in_break); end
    resume = 1'b1;
    pulses = 0; first_pc = 16'hffff;
    for (int k = 0; k < 8; k++) begin
      tick_clk();
      if (pipe_en) begin
        if (pulses == 0) first_pc = strobe_pc;
        pulses++;
      end
    end
    checks++; if (first_pc !== 16'h0010) begin errors++; $display("FAIL bp_resume_pc: got %04h want 0010", first_pc); end
    checks++; if (pulses !== 6) begin errors++; $display("FAIL bp_resume_pulses: got %0d want 6", pulses); end
    checks++; if (running !== 1'b1 || in_break !== 1'b0) begin errors++; $display("FAIL bp_resume_state: got run=%0b brk=%0b want 1/0", running, in_break); end
    checks++; if (adv_count !== 16'd29) begin errors++; $display("FAIL bp_adv_count: got %0d want 29", adv_count); end
    mode = 2'b00; resume = 1'b0;
    repeat (3) tick_clk();
  endtask

  task automatic test_reset_mid_burst();
    bit found;
    int pulses;
    bp_en = 2'b00; mode = 2'b11; burst_len = 16'd10; rate_div = 26'd0; step_btn = 1'b0;
    repeat (2) tick_clk();
    step_btn = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick_clk();
      if (burst_left == 16'd3) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL mid_burst_timeout: got no burst_left=3 want seen within 60 cycles"); end
    reset = 1'b0;
    tick_clk();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL mid_reset_running: got %0b want 0", running); end
    checks++; if (burst_left !== 16'd0) begin errors++; $display("FAIL mid_reset_burst_left: got %0d want 0", burst_left); end
    checks++; if (pipe_en !== 1'b0) begin errors++; $display("FAIL mid_reset_pipe_en: got %0b want 0", pipe_en); end
    checks++; if (adv_count !== 16'd0) begin errors++; $display("FAIL mid_reset_adv_count: got %0d want 0", adv_count); end
    tick_clk();
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick_clk();
      if (pipe_en) pulses++;
    end
    checks++; if (pulses !== 0 || running !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %0d strobes run=%0b want 0/0", pulses, running); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    strobe_pc = 16'd0;
    test_reset();
    test_free_run();
    test_step();
    test_burst();
    test_breakpoint();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
